// File: rtl/ingress_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : ingress_rr_sched
//  Purpose  : Four-requester ingress scheduler; per-input FIFOs drained
//             round-robin onto one registered, stallable output.
//  Revision : 1.0
// ============================================================================
module ingress_rr_sched #(
    parameter int DATA_WIDTH = 480,
    parameter int CTRL_WIDTH = 32,
    parameter int NUM_QUEUES = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_QUEUES-1:0]            in_wr,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctl,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
    input  logic                             out_stall,
    output logic                             out_wr,
    output logic [CTRL_WIDTH-1:0]            out_ctl,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [1:0]                       out_src,
    output logic [NUM_QUEUES-1:0]            full,
    output logic [NUM_QUEUES*CNT_WIDTH-1:0]  drop_cnt
);

    localparam int                   c_word_w   = CTRL_WIDTH + DATA_WIDTH;
    localparam logic [FIFO_AW:0]     c_full_cnt = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max  = '1;

    logic                  r_out_wr;
    logic [CTRL_WIDTH-1:0] r_out_ctl;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [1:0]            r_out_src;
    logic [1:0]            r_last_grant;

    logic [NUM_QUEUES-1:0] w_empty;
    logic [c_word_w-1:0]   w_head [NUM_QUEUES];
    logic                  w_adv;
    logic                  w_any;
    logic [1:0]            w_gnt;
    logic [1:0]            w_idx;

    assign w_adv = ~r_out_wr | ~out_stall;

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_q
        logic [c_word_w-1:0]  r_mem [FIFO_DEPTH];
        logic [FIFO_AW-1:0]   r_wptr;
        logic [FIFO_AW-1:0]   r_rptr;
        logic [FIFO_AW:0]     r_count;
        logic [CNT_WIDTH-1:0] r_drop;
        logic                 w_full;
        logic                 w_push;
        logic                 w_pop;

        // Fullness is judged on the pre-edge count, so a same-cycle pop never admits a push.
        assign w_full = (r_count == c_full_cnt);
        assign w_push = in_wr[g] & ~w_full;
        assign w_pop  = w_adv & w_any & (w_gnt == 2'(g));

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wptr] <= {in_ctl[g*CTRL_WIDTH +: CTRL_WIDTH],
                                  in_data[g*DATA_WIDTH +: DATA_WIDTH]};
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
                r_drop  <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
                if (w_push & ~w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (~w_push & w_pop) begin
                    r_count <= r_count - 1'b1;
                end
                if (in_wr[g] & w_full & (r_drop != c_cnt_max)) begin
                    r_drop <= r_drop + 1'b1;
                end
            end
        end

        assign full[g]                            = w_full;
        assign w_empty[g]                         = (r_count == '0);
        assign w_head[g]                          = r_mem[r_rptr];
        assign drop_cnt[g*CNT_WIDTH +: CNT_WIDTH] = r_drop;
    end

    // Scan from the farthest candidate back to the nearest so the nearest non-empty wins.
    always_comb begin
        w_any = 1'b0;
        w_gnt = r_last_grant;
        w_idx = '0;
        for (int k = NUM_QUEUES; k >= 1; k--) begin
            w_idx = r_last_grant + 2'(k);
            if (!w_empty[w_idx]) begin
                w_any = 1'b1;
                w_gnt = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_wr     <= 1'b0;
            r_out_ctl    <= '0;
            r_out_data   <= '0;
            r_out_src    <= '0;
            r_last_grant <= 2'd3;
        end else if (w_adv) begin
            if (w_any) begin
                r_out_wr                 <= 1'b1;
                {r_out_ctl, r_out_data}  <= w_head[w_gnt];
                r_out_src                <= w_gnt;
                r_last_grant             <= w_gnt;
            end else begin
                r_out_wr <= 1'b0;
            end
        end
    end

    assign out_wr   = r_out_wr;
    assign out_ctl  = r_out_ctl;
    assign out_data = r_out_data;
    assign out_src  = r_out_src;

endmodule
`default_nettype wire
